rename_dispatch_ss: RTL



---
 rtl/rv32i_types.sv | 55 +++++
 rtl/rename_bypass.sv | 85 ++++++++
 rtl/rename_dispatch_ss.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the rename/dispatch slice: decoded group slots, RVFI record,
// physical register triple and the reservation-station dispatch entry.
package rv32i_types;

    localparam int unsigned PKG_SS          = 2;
    localparam int unsigned PKG_PR_ENTRIES  = 64;
    localparam int unsigned PKG_ROB_ENTRIES = 32;
    localparam int unsigned PKG_PRW         = $clog2(PKG_PR_ENTRIES);
    localparam int unsigned PKG_RBW         = $clog2(PKG_ROB_ENTRIES);

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [4:0]  rd_s;
    } instruction_info_reg_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_t;

    typedef struct packed {
        logic [PKG_PRW-1:0] rs1;
        logic [PKG_PRW-1:0] rs2;
        logic [PKG_PRW-1:0] rd;
    } physical_reg_data_t;

    typedef struct packed {
        rvfi_t              rvfi;
        logic [31:0]        inst;
        physical_reg_data_t rat;
        logic               rs1_met;
        logic               rs2_met;
        logic [PKG_RBW-1:0] rob_id;
    } dispatch_reservation_t;

endpackage

// File: rtl/rename_bypass.sv
// Combinational intra-group rename: destination allocation from the free list,
// source mapping with bypass from earlier slots, and the last-writer RAT mask.
module rename_bypass
    import rv32i_types::*;
#(
    parameter int unsigned SS  = PKG_SS,
    parameter int unsigned PRW = PKG_PRW,
    localparam int unsigned CW = $clog2(SS) + 1
) (
    input  instruction_info_reg_t i_inst      [SS],
    input  logic [PRW-1:0]        i_rat_rs1   [SS],
    input  logic [PRW-1:0]        i_rat_rs2   [SS],
    input  logic                  i_rdy_rs1   [SS],
    input  logic                  i_rdy_rs2   [SS],
    input  logic [PRW-1:0]        i_fl_regs   [SS],
    output logic [PRW-1:0]        o_rd_phys   [SS],
    output logic [PRW-1:0]        o_rs1_phys  [SS],
    output logic [PRW-1:0]        o_rs2_phys  [SS],
    output logic                  o_rs1_met   [SS],
    output logic                  o_rs2_met   [SS],
    output logic                  o_last_wr   [SS],
    output logic [CW-1:0]         o_need_pr,
    output logic [CW-1:0]         o_nvalid
);

    logic w_writes [SS];

    // Writing slots take free registers in slot order; count writers and valid slots
    always_comb begin
        o_need_pr = '0;
        o_nvalid  = '0;
        for (int i = 0; i < SS; i++) begin
            w_writes[i]  = i_inst[i].valid && (i_inst[i].rd_s != 5'd0);
            o_rd_phys[i] = '0;
            if (i_inst[i].valid) begin
                o_nvalid = o_nvalid + CW'(1);
            end
            if (w_writes[i]) begin
                o_rd_phys[i] = i_fl_regs[int'(o_need_pr)];
                o_need_pr    = o_need_pr + CW'(1);
            end
        end
    end

    // A RAT write survives only if no later slot in the group writes the same arch reg
    always_comb begin
        for (int i = 0; i < SS; i++) begin
            o_last_wr[i] = w_writes[i];
            for (int j = i + 1; j < SS; j++) begin
                if (w_writes[j] && (i_inst[j].rd_s == i_inst[i].rd_s)) begin
                    o_last_wr[i] = 1'b0;
                end
            end
        end
    end

    // Sources: RAT by default, nearest earlier in-group writer overrides, x0 is always ready
    always_comb begin
        for (int i = 0; i < SS; i++) begin
            o_rs1_phys[i] = i_rat_rs1[i];
            o_rs1_met[i]  = i_rdy_rs1[i];
            o_rs2_phys[i] = i_rat_rs2[i];
            o_rs2_met[i]  = i_rdy_rs2[i];
            for (int j = 0; j < i; j++) begin
                if (w_writes[j] && (i_inst[j].rd_s == i_inst[i].rs1_s)) begin
                    o_rs1_phys[i] = o_rd_phys[j];
                    o_rs1_met[i]  = 1'b0;
                end
                if (w_writes[j] && (i_inst[j].rd_s == i_inst[i].rs2_s)) begin
                    o_rs2_phys[i] = o_rd_phys[j];
                    o_rs2_met[i]  = 1'b0;
                end
            end
            if (i_inst[i].rs1_s == 5'd0) begin
                o_rs1_phys[i] = '0;
                o_rs1_met[i]  = 1'b1;
            end
            if (i_inst[i].rs2_s == 5'd0) begin
                o_rs2_phys[i] = '0;
                o_rs2_met[i]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rename_dispatch_ss.sv
// Superscalar rename/dispatch stage: accepts a decoded group, renames it,
// allocates free-list and ROB resources and holds one registered dispatch
// group for the reservation stations, snooping the CDB while stalled.
// Entry field widths come from rv32i_types; parameters must agree with it.
module rename_dispatch_ss
    import rv32i_types::*;
#(
    parameter int unsigned SS          = PKG_SS,
    parameter int unsigned PR_ENTRIES  = PKG_PR_ENTRIES,
    parameter int unsigned ROB_ENTRIES = PKG_ROB_ENTRIES,
    localparam int unsigned PRW = $clog2(PR_ENTRIES),
    localparam int unsigned RBW = $clog2(ROB_ENTRIES),
    localparam int unsigned CW  = $clog2(SS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  instruction_info_reg_t in_inst      [SS],
    output logic [4:0]            isa_rs1      [SS],
    output logic [4:0]            isa_rs2      [SS],
    input  logic [PRW-1:0]        rat_rs1      [SS],
    input  logic [PRW-1:0]        rat_rs2      [SS],
    input  logic                  pr_ready_rs1 [SS],
    input  logic                  pr_ready_rs2 [SS],
    output logic                  rat_we       [SS],
    output logic [4:0]            rat_rd_arch  [SS],
    output logic [PRW-1:0]        rat_rd_phys  [SS],
    input  logic [PRW:0]          fl_count,
    input  logic [PRW-1:0]        fl_regs      [SS],
    output logic [CW-1:0]         fl_pop,
    input  logic [RBW:0]          rob_space,
    input  logic [RBW-1:0]        rob_tail,
    output logic [CW-1:0]         rob_alloc,
    input  logic                  cdb_valid,
    input  logic [PRW-1:0]        cdb_preg,
    output logic                  rs_valid,
    input  logic                  rs_ready,
    output dispatch_reservation_t rs_entries   [SS]
);

    localparam int unsigned FCW = PRW + 1;
    localparam int unsigned RCW = RBW + 1;

    logic                  r_rs_valid;
    logic [63:0]           r_order;
    dispatch_reservation_t r_entries [SS];

    logic [PRW-1:0]        w_rd_phys  [SS];
    logic [PRW-1:0]        w_rs1_phys [SS];
    logic [PRW-1:0]        w_rs2_phys [SS];
    logic                  w_rs1_met  [SS];
    logic                  w_rs2_met  [SS];
    logic                  w_last_wr  [SS];
    logic [CW-1:0]         w_need_pr;
    logic [CW-1:0]         w_nvalid;
    logic                  w_out_free;
    logic                  w_fire;
    dispatch_reservation_t w_entries [SS];

    rename_bypass #(
        .SS  (SS),
        .PRW (PRW)
    ) u_bypass (
        .i_inst     (in_inst),
        .i_rat_rs1  (rat_rs1),
        .i_rat_rs2  (rat_rs2),
        .i_rdy_rs1  (pr_ready_rs1),
        .i_rdy_rs2  (pr_ready_rs2),
        .i_fl_regs  (fl_regs),
        .o_rd_phys  (w_rd_phys),
        .o_rs1_phys (w_rs1_phys),
        .o_rs2_phys (w_rs2_phys),
        .o_rs1_met  (w_rs1_met),
        .o_rs2_met  (w_rs2_met),
        .o_last_wr  (w_last_wr),
        .o_need_pr  (w_need_pr),
        .o_nvalid   (w_nvalid)
    );

    // Accept a group only when the output slot frees up and resources cover it
    always_comb begin
        w_out_free = !r_rs_valid || rs_ready;
        w_fire     = in_valid && w_out_free && !flush && !rst
                     && (fl_count >= FCW'(w_need_pr))
                     && (rob_space >= RCW'(w_nvalid));
        in_ready   = w_fire;
        fl_pop     = w_fire ? w_need_pr : '0;
        rob_alloc  = w_fire ? w_nvalid  : '0;
    end

    // RAT read addresses and last-writer-wins write port
    always_comb begin
        for (int i = 0; i < SS; i++) begin
            isa_rs1[i]     = in_inst[i].rs1_s;
            isa_rs2[i]     = in_inst[i].rs2_s;
            rat_we[i]      = w_fire && w_last_wr[i];
            rat_rd_arch[i] = in_inst[i].rd_s;
            rat_rd_phys[i] = w_rd_phys[i];
        end
    end

    // Build the next dispatch entries; ROB id and order advance per valid slot
    always_comb begin
        logic [CW-1:0] vidx;
        vidx = '0;
        for (int i = 0; i < SS; i++) begin
            w_entries[i]                = '0;
            w_entries[i].rvfi.valid     = in_inst[i].valid;
            w_entries[i].rvfi.order     = r_order + 64'(vidx);
            w_entries[i].rvfi.inst      = in_inst[i].inst;
            w_entries[i].rvfi.rs1_addr  = in_inst[i].rs1_s;
            w_entries[i].rvfi.rs2_addr  = in_inst[i].rs2_s;
            w_entries[i].rvfi.rd_addr   = in_inst[i].rd_s;
            w_entries[i].rvfi.pc_rdata  = in_inst[i].pc;
            w_entries[i].rvfi.pc_wdata  = in_inst[i].pc_next;
            w_entries[i].rvfi.rs1_rdata = 'x;
            w_entries[i].rvfi.rs2_rdata = 'x;
            w_entries[i].rvfi.rd_wdata  = 'x;
            w_entries[i].rvfi.mem_addr  = 'x;
            w_entries[i].rvfi.mem_rmask = 'x;
            w_entries[i].rvfi.mem_wmask = 'x;
            w_entries[i].rvfi.mem_rdata = 'x;
            w_entries[i].rvfi.mem_wdata = 'x;
            w_entries[i].inst           = in_inst[i].inst;
            w_entries[i].rat.rs1        = w_rs1_phys[i];
            w_entries[i].rat.rs2        = w_rs2_phys[i];
            w_entries[i].rat.rd         = w_rd_phys[i];
            w_entries[i].rs1_met        = w_rs1_met[i] || (cdb_valid && (w_rs1_phys[i] != '0)
                                                           && (w_rs1_phys[i] == cdb_preg));
            w_entries[i].rs2_met        = w_rs2_met[i] || (cdb_valid && (w_rs2_phys[i] != '0)
                                                           && (w_rs2_phys[i] == cdb_preg));
            w_entries[i].rob_id         = rob_tail + RBW'(vidx);
            if (in_inst[i].valid) begin
                vidx = vidx + CW'(1);
            end
        end
    end

    // Output register: latch on fire, drop on accept or flush, snoop CDB while held
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs_valid <= 1'b0;
            r_order    <= '0;
        end else if (flush) begin
            r_rs_valid <= 1'b0;
        end else if (w_fire) begin
            r_rs_valid <= 1'b1;
            r_entries  <= w_entries;
            r_order    <= r_order + 64'(w_nvalid);
        end else if (r_rs_valid) begin
            if (rs_ready) begin
                r_rs_valid <= 1'b0;
            end else begin
                for (int i = 0; i < SS; i++) begin
                    if (cdb_valid && (cdb_preg != '0) && (r_entries[i].rat.rs1 == cdb_preg)) begin
                        r_entries[i].rs1_met <= 1'b1;
                    end
                    if (cdb_valid && (cdb_preg != '0) && (r_entries[i].rat.rs2 == cdb_preg)) begin
                        r_entries[i].rs2_met <= 1'b1;
                    end
                end
            end
        end
    end

    assign rs_valid   = r_rs_valid;
    assign rs_entries = r_entries;

endmodule
